edge_trigger_array: RTL and testbench

Multi-channel, parametrised edge trigger. Each channel:
- synchronises an asynchronous input;
- optionally rejects glitches shorter than a programmable stable time;
- emits a one-clock pulse on a selectable edge (rise, fall, both, off).

Each channel also keeps a sticky event flag and a saturating event counter, both cleared per channel. It sits between raw board/PHY status lines and the sniffer control logic. It replaces the single-channel, rise-only pulse generator.

---
 rtl/edge_trigger_pkg.sv | 19 +
 rtl/edge_trigger_channel.sv | 82 ++++++++
 rtl/edge_trigger_array.sv | 42 ++++
 tb/tb_edge_trigger_array.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_trigger_pkg.sv
// Shared constants and helpers for the multi-channel edge trigger.
package edge_trigger_pkg;

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_RISE = 2'b01;
  localparam logic [1:0] MODE_FALL = 2'b10;
  localparam logic [1:0] MODE_BOTH = 2'b11;

  // Ceiling log2; clog2(1) = 0, so callers apply their own minimum width.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/edge_trigger_channel.sv
// One trigger channel: synchroniser, glitch filter, edge detect, sticky flag
// and saturating event counter.
module edge_trigger_channel
  import edge_trigger_pkg::*;
#(
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 0,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 input_signal,
  input  logic [1:0]           mode,
  input  logic                 clear,
  output logic                 output_signal,
  output logic                 level,
  output logic                 event_flag,
  output logic [CNT_WIDTH-1:0] event_count
);

  localparam int unsigned FILT_W = (clog2(FILTER_CYCLES + 1) > 1) ? clog2(FILTER_CYCLES + 1) : 1;
  localparam logic [FILT_W-1:0]    FILT_MAX = FILT_W'(FILTER_CYCLES);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic [FILT_W-1:0]      filt_q;
  logic                   prev_q;
  logic                   s_c;
  logic                   rise_c;
  logic                   fall_c;
  logic                   fire_c;

  assign s_c    = sync_q[SYNC_STAGES-1];
  assign rise_c = level & ~prev_q;
  assign fall_c = ~level & prev_q;
  assign fire_c = (rise_c && (mode == MODE_RISE || mode == MODE_BOTH)) ||
                  (fall_c && (mode == MODE_FALL || mode == MODE_BOTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], input_signal};
  end

  // A new level is accepted only after it has differed for FILTER_CYCLES+1 edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level  <= 1'b0;
      filt_q <= '0;
    end else if (s_c != level) begin
      if (filt_q == FILT_MAX) begin
        level  <= s_c;
        filt_q <= '0;
      end else begin
        filt_q <= filt_q + FILT_W'(1);
      end
    end else begin
      filt_q <= '0;
    end
  end

  // Edge history runs regardless of mode; a pulse beats a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q        <= 1'b0;
      output_signal <= 1'b0;
      event_flag    <= 1'b0;
      event_count   <= '0;
    end else begin
      prev_q        <= level;
      output_signal <= fire_c;
      if (fire_c) begin
        event_flag <= 1'b1;
        if (clear)                   event_count <= CNT_WIDTH'(1);
        else if (event_count != CNT_MAX) event_count <= event_count + CNT_WIDTH'(1);
      end else if (clear) begin
        event_flag  <= 1'b0;
        event_count <= '0;
      end
    end
  end

endmodule

// File: rtl/edge_trigger_array.sv
// Multi-channel edge trigger: independent channels, each with its own mode,
// clear, level, flag and counter slice.
module edge_trigger_array
  import edge_trigger_pkg::*;
#(
  parameter int unsigned CHANNELS      = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned FILTER_CYCLES = 0,
  parameter int unsigned CNT_WIDTH     = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           input_signal,
  input  logic [2*CHANNELS-1:0]         mode,
  input  logic [CHANNELS-1:0]           clear,
  output logic [CHANNELS-1:0]           output_signal,
  output logic [CHANNELS-1:0]           level,
  output logic [CHANNELS-1:0]           event_flag,
  output logic [CNT_WIDTH*CHANNELS-1:0] event_count
);

  localparam int unsigned MODE_W = $bits(MODE_OFF);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    edge_trigger_channel #(
      .SYNC_STAGES  (SYNC_STAGES),
      .FILTER_CYCLES(FILTER_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .input_signal (input_signal[i]),
      .mode         (mode[MODE_W*i +: MODE_W]),
      .clear        (clear[i]),
      .output_signal(output_signal[i]),
      .level        (level[i]),
      .event_flag   (event_flag[i]),
      .event_count  (event_count[CNT_WIDTH*i +: CNT_WIDTH])
    );
  end

endmodule

// File: tb/tb_edge_trigger_array.sv
// Bench for edge_trigger_array: two instances (unfiltered 2-bit counters and
// F=3 8-bit counters) checked against an event-level reference model.
module tb_edge_trigger_array;

  localparam int unsigned CH   = 4;
  localparam int unsigned SS   = 2;
  localparam int unsigned CW_A = 2;
  localparam int unsigned CW_B = 8;

  logic clk = 1'b0;
  logic rst;
  logic [CH-1:0]      input_signal;
  logic [CH-1:0]      clear;
  logic [2*CH-1:0]    mode;
  logic [CH-1:0]      out_a, level_a, flag_a;
  logic [CH-1:0]      out_b, level_b, flag_b;
  logic [CW_A*CH-1:0] count_a;
  logic [CW_B*CH-1:0] count_b;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  edge_trigger_array #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(0), .CNT_WIDTH(CW_A)) dut_a (
    .clk(clk), .rst(rst), .input_signal(input_signal), .mode(mode), .clear(clear),
    .output_signal(out_a), .level(level_a), .event_flag(flag_a), .event_count(count_a)
  );

  edge_trigger_array #(.CHANNELS(CH), .SYNC_STAGES(SS), .FILTER_CYCLES(3), .CNT_WIDTH(CW_B)) dut_b (
    .clk(clk), .rst(rst), .input_signal(input_signal), .mode(mode), .clear(clear),
    .output_signal(out_b), .level(level_b), .event_flag(flag_b), .event_count(count_b)
  );

  // Reference model: d=0 mirrors dut_a, d=1 mirrors dut_b.
  function automatic int filt_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic int cmax_of(input int d);
    return (d == 0) ? (1 << CW_A) - 1 : (1 << CW_B) - 1;
  endfunction

  int m_sync [2][CH][SS];
  int m_level[2][CH];
  int m_run  [2][CH];
  int m_acc  [2][CH];   // direction accepted at the last edge: 0 none, 1 rise, 2 fall
  int m_out  [2][CH];
  int m_flag [2][CH];
  int m_count[2][CH];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < CH; c++) begin
          for (int j = 0; j < SS; j++) m_sync[d][c][j] = 0;
          m_level[d][c] = 0; m_run[d][c] = 0; m_acc[d][c] = 0;
          m_out[d][c] = 0; m_flag[d][c] = 0; m_count[d][c] = 0;
        end
    end else begin
      for (int d = 0; d < 2; d++)
        for (int c = 0; c < CH; c++) begin
          int md;
          int fire;
          int s;
          md = int'(mode[2*c +: 2]);
          fire = ((m_acc[d][c] == 1) && (md == 1 || md == 3)) ||
                 ((m_acc[d][c] == 2) && (md == 2 || md == 3)) ? 1 : 0;
          m_out[d][c] = fire;
          if (fire == 1) begin
            m_flag[d][c] = 1;
            if (clear[c]) m_count[d][c] = 1;
            else if (m_count[d][c] < cmax_of(d)) m_count[d][c] = m_count[d][c] + 1;
          end else if (clear[c]) begin
            m_flag[d][c] = 0;
            m_count[d][c] = 0;
          end
          s = m_sync[d][c][SS-1];
          m_acc[d][c] = 0;
          if (s != m_level[d][c]) begin
            m_run[d][c] = m_run[d][c] + 1;
            if (m_run[d][c] > filt_of(d)) begin
              m_level[d][c] = s;
              m_run[d][c] = 0;
              m_acc[d][c] = (s == 1) ? 1 : 2;
            end
          end else begin
            m_run[d][c] = 0;
          end
          for (int j = SS - 1; j > 0; j--) m_sync[d][c][j] = m_sync[d][c][j-1];
          m_sync[d][c][0] = int'(input_signal[c]);
        end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int c = 0; c < CH; c++) begin
      check($sformatf("a_out%0d", c),   32'(out_a[c]),   32'(m_out[0][c]));
      check($sformatf("a_level%0d", c), 32'(level_a[c]), 32'(m_level[0][c]));
      check($sformatf("a_flag%0d", c),  32'(flag_a[c]),  32'(m_flag[0][c]));
      check($sformatf("a_count%0d", c), 32'(count_a[CW_A*c +: CW_A]), 32'(m_count[0][c]));
      check($sformatf("b_out%0d", c),   32'(out_b[c]),   32'(m_out[1][c]));
      check($sformatf("b_level%0d", c), 32'(level_b[c]), 32'(m_level[1][c]));
      check($sformatf("b_flag%0d", c),  32'(flag_b[c]),  32'(m_flag[1][c]));
      check($sformatf("b_count%0d", c), 32'(count_b[CW_B*c +: CW_B]), 32'(m_count[1][c]));
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; input_signal = '0; clear = '0; mode = 8'h55;
    @(negedge clk);
    check("rst_out",   32'({out_a, out_b}), 32'd0);
    check("rst_flag",  32'({flag_a, flag_b}), 32'd0);
    check("rst_count", 32'(count_a) | count_b, 32'd0);
    check("rst_level", 32'({level_a, level_b}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    ticks(6);

    // Rise on ch0: unfiltered pulse after edge k+3, filtered after edge k+6
    input_signal[0] = 1'b1;
    ticks(3);
    check("s1_early", 32'(out_a), 32'd0);
    tick();
    check("s1_pulse", 32'(out_a), 32'b0001);
    check("s1_count", 32'(count_a), 32'd1);
    tick();
    check("s1_single", 32'(out_a[0]), 32'd0);
    tick();
    check("s1_b_early", 32'(out_b[0]), 32'd0);
    tick();
    check("s1_b_pulse", 32'(out_b[0]), 32'd1);
    ticks(2);

    // Both-edge mode on ch1, 5-cycle high
    mode[3:2] = 2'b11;
    input_signal[1] = 1'b1;
    ticks(3);
    tick();
    check("s2_rise", 32'(out_a[1]), 32'd1);
    tick();
    check("s2_single", 32'(out_a[1]), 32'd0);
    input_signal[1] = 1'b0;
    ticks(3);
    check("s2_gap", 32'(out_a[1]), 32'd0);
    tick();
    check("s2_fall", 32'(out_a[1]), 32'd1);
    check("s2_count", 32'(count_a[3:2]), 32'd2);
    check("s2_flag", 32'(flag_a[1]), 32'd1);
    ticks(8);

    // 3-cycle glitch on ch2 is rejected by the F=3 instance
    input_signal[2] = 1'b1;
    ticks(3);
    input_signal[2] = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      check("s3_glitch_level", 32'(level_b[2]), 32'd0);
    end
    check("s3_glitch_count", 32'(count_b[23:16]), 32'd0);
    input_signal[2] = 1'b1;
    ticks(6);
    check("s3_b_early", 32'(out_b[2]), 32'd0);
    tick();
    check("s3_b_pulse", 32'(out_b[2]), 32'd1);
    check("s3_b_count", 32'(count_b[23:16]), 32'd1);
    ticks(4);
    input_signal[2] = 1'b0;
    ticks(10);

    // Saturation of the 2-bit counter on ch0
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    check("s4_cleared", 32'({flag_a[0], count_a[1:0]}), 32'd0);
    input_signal[0] = 1'b0;
    ticks(8);
    for (int n = 0; n < 5; n++) begin
      input_signal[0] = 1'b1;
      ticks(4);
      check("s4_pulse", 32'(out_a[0]), 32'd1);
      check("s4_count", 32'(count_a[1:0]), 32'((n + 1 > 3) ? 3 : n + 1));
      input_signal[0] = 1'b0;
      ticks(4);
    end
    input_signal[0] = 1'b1;
    ticks(3);
    clear[0] = 1'b1;
    tick();
    clear[0] = 1'b0;
    check("s4_clr_pulse", 32'(out_a[0]), 32'd1);
    check("s4_clr_count", 32'(count_a[1:0]), 32'd1);
    check("s4_clr_flag", 32'(flag_a[0]), 32'd1);
    input_signal[0] = 1'b0;
    ticks(8);

    // Mode off on ch3 still tracks level; enabling does not replay an old edge
    mode[7:6] = 2'b00;
    for (int n = 0; n < 4; n++) begin
      input_signal[3] = ~input_signal[3];
      ticks(10);
    end
    input_signal[3] = 1'b1;
    ticks(10);
    check("s5_level_a", 32'(level_a[3]), 32'd1);
    check("s5_level_b", 32'(level_b[3]), 32'd1);
    check("s5_off_count", 32'({flag_a[3], count_a[7:6]}), 32'd0);
    mode[7:6] = 2'b01;
    ticks(10);
    check("s5_no_replay", 32'({flag_a[3], count_a[7:6]}), 32'd0);
    input_signal[3] = 1'b0;
    ticks(10);
    input_signal[3] = 1'b1;
    ticks(3);
    tick();
    check("s5_pulse", 32'(out_a[3]), 32'd1);
    check("s5_count", 32'(count_a[7:6]), 32'd1);
    ticks(8);

    // Asynchronous reset in the middle of a pulse
    input_signal[1] = 1'b1;
    ticks(3);
    tick();
    check("s6_pre_pulse", 32'(out_a[1]), 32'd1);
    input_signal[0] = 1'b1;
    #1 rst = 1'b1;
    #1;
    check("s6_async_out", 32'({out_a, out_b}), 32'd0);
    check("s6_async_flag", 32'({flag_a, flag_b}), 32'd0);
    check("s6_async_count", 32'(count_a) | count_b, 32'd0);
    check_all();
    ticks(2);
    rst = 1'b0;
    ticks(3);
    check("s6_rel_early", 32'(out_a[0]), 32'd0);
    tick();
    check("s6_rel_pulse", 32'(out_a[0]), 32'd1);
    ticks(6);
    check("s6_rel_once", 32'(count_a[1:0]), 32'd1);

    // Random activity against the model
    repeat (400) begin
      for (int c = 0; c < CH; c++)
        if ($urandom_range(0, 3) == 0) input_signal[c] = ~input_signal[c];
      if ($urandom_range(0, 15) == 0) mode = 8'($urandom);
      clear = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
